// File: rtl/oled_pkg.sv
// rtl/oled_pkg.sv - shared OLED geometry, colour constants and arbiter state encoding
package oled_pkg;

   localparam int OLED_W      = 96;
   localparam int OLED_H      = 64;
   localparam int OLED_PIXELS = OLED_W * OLED_H;
   localparam int CLK_HZ      = 6250000;

   localparam logic [15:0] BLACK  = 16'h0000;
   localparam logic [15:0] RED    = 16'hF800;
   localparam logic [15:0] ORANGE = 16'hFC00;
   localparam logic [15:0] GREEN  = 16'h07E0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RESTART = 2'd1,
      ST_BLANK   = 2'd2,
      ST_RUN     = 2'd3
   } arb_state_t;

endpackage

// File: rtl/btn_event_gen.sv
// rtl/btn_event_gen.sv - push-button synchroniser, rising-edge detect and press lockout
module btn_event_gen #(
   parameter int LOCKOUT_CYCLES = 1249999
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_btn,
   output logic o_accept
);

   localparam int CW = $clog2(LOCKOUT_CYCLES + 1);

   logic          r_s1;
   logic          r_s2;
   logic          r_s3;
   logic [CW-1:0] r_lock;
   logic          w_rise;

   assign w_rise   = r_s2 & ~r_s3;
   assign o_accept = w_rise && (r_lock == '0);

   // The lockout is loaded on every accepted press, even one the arbiter then drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1   <= 1'b0;
         r_s2   <= 1'b0;
         r_s3   <= 1'b0;
         r_lock <= '0;
      end else begin
         r_s1 <= i_btn;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
         if (o_accept) begin
            r_lock <= CW'(LOCKOUT_CYCLES);
         end else if (r_lock != '0) begin
            r_lock <= r_lock - CW'(1);
         end
      end
   end

endmodule

// File: rtl/oled_task_arbiter.sv
// rtl/oled_task_arbiter.sv - shares the OLED pixel path and buttons between task renderers
module oled_task_arbiter
   import oled_pkg::*;
#(
   parameter int N_TASKS        = 4,
   parameter int LOCKOUT_CYCLES = 1249999,
   parameter int FRAME_PIXELS   = OLED_PIXELS
) (
   input  logic                   clk_6p25m,
   input  logic                   rst_n,
   input  logic [4:1]             sw,
   input  logic                   btnC,
   input  logic                   btnD,
   input  logic [12:0]            pixel_index,
   input  logic [16*N_TASKS-1:0]  task_data,
   output logic [15:0]            oled_data,
   output logic [N_TASKS-1:0]     task_grant,
   output logic [N_TASKS-1:0]     task_restart,
   output logic [N_TASKS-1:0]     btnC_evt,
   output logic [N_TASKS-1:0]     btnD_evt,
   output logic [1:0]             active_id
);

   localparam int CNT_W = $clog2(FRAME_PIXELS);

   logic [4:1]         r_sw_s1;
   logic [4:1]         r_sw_s2;
   arb_state_t         r_state;
   arb_state_t         w_next;
   logic [1:0]         r_id;
   logic [1:0]         w_sel;
   logic               w_sel_valid;
   logic               w_load_id;
   logic [CNT_W-1:0]   r_blank_cnt;
   logic               r_armed;
   logic               w_count;
   logic               w_frame_done;
   logic [15:0]        r_oled;
   logic [N_TASKS-1:0] w_id_onehot;
   logic [N_TASKS-1:0] r_evt_c;
   logic [N_TASKS-1:0] r_evt_d;
   logic               w_accept_c;
   logic               w_accept_d;

   btn_event_gen #(.LOCKOUT_CYCLES(LOCKOUT_CYCLES)) u_btn_c (
      .clk      (clk_6p25m),
      .rst_n    (rst_n),
      .i_btn    (btnC),
      .o_accept (w_accept_c)
   );

   btn_event_gen #(.LOCKOUT_CYCLES(LOCKOUT_CYCLES)) u_btn_d (
      .clk      (clk_6p25m),
      .rst_n    (rst_n),
      .i_btn    (btnD),
      .o_accept (w_accept_d)
   );

   always_comb begin
      w_sel       = '0;
      w_sel_valid = ($countones(r_sw_s2) == 1);
      for (int i = 1; i <= 4; i++) begin
         if (r_sw_s2[i]) begin
            w_sel = 2'(i - 1);
         end
      end
   end

   assign w_id_onehot = N_TASKS'(1) << r_id;

   // Blank counting starts on the first pixel 0 seen in BLANK and then runs a whole frame.
   assign w_count      = (r_state == ST_BLANK) && (r_armed || (pixel_index == '0));
   assign w_frame_done = w_count && (r_blank_cnt == CNT_W'(FRAME_PIXELS - 1));

   always_ff @(posedge clk_6p25m or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next       = r_state;
      task_grant   = '0;
      task_restart = '0;
      case (r_state)
         ST_IDLE:    if (w_sel_valid) w_next = ST_RESTART;
         ST_RESTART: begin
            task_restart = w_id_onehot;
            w_next       = ST_BLANK;
         end
         ST_BLANK:   if (w_frame_done) w_next = ST_RUN;
         ST_RUN:     task_grant = w_id_onehot;
         default:    w_next = ST_IDLE;
      endcase
      // A selection change overrides whatever the current state wanted to do.
      if (r_state != ST_IDLE) begin
         if (!w_sel_valid) begin
            w_next = ST_IDLE;
         end else if (w_sel != r_id) begin
            w_next = ST_RESTART;
         end
      end
      w_load_id = (w_next == ST_RESTART);
   end

   always_ff @(posedge clk_6p25m or negedge rst_n) begin
      if (!rst_n) begin
         r_sw_s1     <= '0;
         r_sw_s2     <= '0;
         r_id        <= '0;
         r_blank_cnt <= '0;
         r_armed     <= 1'b0;
         r_oled      <= BLACK;
         r_evt_c     <= '0;
         r_evt_d     <= '0;
      end else begin
         r_sw_s1 <= sw;
         r_sw_s2 <= r_sw_s1;
         if (w_load_id) begin
            r_id <= w_sel;
         end
         if ((r_state != ST_BLANK) || w_frame_done) begin
            r_blank_cnt <= '0;
            r_armed     <= 1'b0;
         end else if (w_count) begin
            r_blank_cnt <= r_blank_cnt + CNT_W'(1);
            r_armed     <= 1'b1;
         end
         r_oled  <= (r_state == ST_RUN) ? task_data[16*r_id +: 16] : BLACK;
         r_evt_c <= (w_accept_c && (r_state == ST_RUN)) ? w_id_onehot : '0;
         r_evt_d <= (w_accept_d && (r_state == ST_RUN)) ? w_id_onehot : '0;
      end
   end

   assign oled_data = r_oled;
   assign btnC_evt  = r_evt_c;
   assign btnD_evt  = r_evt_d;
   assign active_id = r_id;

endmodule

// File: doc/oled_task_arbiter.md
# oled_task_arbiter

Shares the single 96x64 OLED pixel path and the two push-buttons (btnC, btnD) between up to four task renderers. Slide switches choose the renderer. On each change of selection the block restarts the new renderer, blanks the panel for one full frame, and then grants it the display. Debounced button events go only to the renderer that owns the display. It sits between the task renderers and the OLED driver, in the 6.25 MHz domain.

## Interface
Parameters:
- `N_TASKS`, 4: number of renderers; fixed at 4 in this revision.
- `LOCKOUT_CYCLES`, 1249999: button lockout after an accepted press (200 ms at 6.25 MHz).
- `FRAME_PIXELS`, 6144: pixels per frame (96*64).

Ports:
- `clk_6p25m` in 1: pixel clock, the only clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sw` in [4:1]: task select switches, asynchronous.
- `btnC`, `btnD` in 1: raw push-buttons, asynchronous.
- `pixel_index` in 13: current pixel from the OLED driver, 0..6143.
- `task_data` in 64: renderer colours; renderer k occupies bits [16k+15:16k].
- `oled_data` out 16: registered colour to the OLED driver.
- `task_grant` out 4: one-hot; high for the renderer that owns the display.
- `task_restart` out 4: one-cycle pulse telling a renderer to clear its state.
- `btnC_evt`, `btnD_evt` out 4: one-cycle press event per renderer.
- `active_id` out 2: index of the granted renderer; valid only while in RUN.

## Operation
- **Input synchronisation:** sw, btnC and btnD each pass through a 2-flop synchroniser before use.
- **Selection decode:**
  - Exactly one sw bit high selects renderer (bit−1).
  - Zero or several bits high mean "no selection".
- **State machine:** IDLE, RESTART, BLANK, RUN.
  - IDLE: oled_data = 0, task_grant = 0. Moves to RESTART when a valid selection appears.
  - RESTART: one cycle. Drives task_restart[sel] = 1 and latches sel as the pending id. Next state is BLANK.
  - BLANK: oled_data = 0. Waits for pixel_index == 0, then counts FRAME_PIXELS cycles. Next state is RUN.
  - RUN: task_grant[id] = 1; oled_data follows task_data of that renderer.
- **Selection change, from any non-IDLE state:**
  - New valid selection → RESTART with the new sel, even mid-BLANK.
  - Selection becomes invalid → IDLE.
  - No restart pulse is sent to the renderer being left.
- **Re-selection of the same renderer:** after passing through IDLE, it is restarted again.
- **Buttons (identical logic for each):**
  - Rising edge of the synchronised level, with the lockout counter at 0 → accepted. Emit evt[id] if in RUN; otherwise drop it. Load the lockout counter with LOCKOUT_CYCLES.
  - The counter decrements to 0 and saturates there.
  - While the counter is non-zero, edges are ignored.
  - Holding the button produces exactly one event.
- **Simultaneous btnC and btnD edges:** both events are emitted in the same cycle.
- **Reset:** evt events are not sent during reset.

## Timing
- Reset values:
  - Outputs: oled_data = 0, task_grant = 0, task_restart = 0, all evt = 0, active_id = 0.
  - Internal: state = IDLE, lockout counters = 0, synchronisers = 0.
- **Mux latency:** oled_data in cycle t+1 reflects task_data at cycle t.
- **Switch latency:** a sw change reaches the FSM after 2 cycles (synchroniser). The restart pulse appears 3 cycles after the sw edge.
- **Button latency:** a btn edge produces evt 3 cycles later (2 synchroniser flops plus edge register).
- **Display handover:** the first granted pixel appears between FRAME_PIXELS+1 and 2*FRAME_PIXELS+1 cycles after RESTART, depending on frame phase.
- **task_grant timing:** goes high in the first RUN cycle. It drops in the same cycle the FSM leaves RUN.
- **Mid-operation reset:** rst_n low forces the reset values immediately (asynchronous). After release, the block restarts from IDLE.

## Structure
- Shared package `oled_pkg` holds:
  - `OLED_W` = 96, `OLED_H` = 64, `OLED_PIXELS` = 6144.
  - `CLK_HZ` = 6250000.
  - Colour constants: `BLACK` = 16'h0000, `RED` = 16'hF800, `ORANGE` = 16'hFC00, `GREEN` = 16'h07E0.
  - FSM state encoding.
- Sub-module `btn_event_gen` (synchroniser, edge detect, lockout counter, parameter LOCKOUT_CYCLES), instantiated twice.

## Test plan
- **Basic selection:** reset, then sw = 4'b0001 → restart[0] pulse, a blanked frame, then grant[0]; task_data0 = 16'hF800 appears at oled_data one cycle later; active_id = 0.
- **Switch change mid-BLANK:** sw 0001 → 0100 during BLANK → restart[2] pulse, blank timing restarts, grant[2] follows; no grant[0] is ever observed.
- **Invalid selection:** sw = 4'b0011 → IDLE, oled_data = 0, no restart; then sw = 0010 → restart[1].
- **Button lockout:**
  - btnD pressed in RUN with id = 1 → btnD_evt[1] pulse 3 cycles later; a second edge 1000 cycles later is ignored.
  - An edge after LOCKOUT_CYCLES+1 cycles → a new event.
  - Hold for 3 M cycles → exactly one event.
- **Press outside RUN:** btnC during BLANK → no evt, lockout still loaded.
- **Asynchronous reset in RUN:** rst_n low mid-frame → all outputs 0 immediately. After release with sw = 0001 still set → full restart sequence repeats.
